// File: rtl/nibble_mux.sv
// Registered 2:1 nibble multiplexer whose channel select toggles on each debounced button press.
// Optional periodic auto-scan of the select is enabled by defining NIBBLE_MUX_AUTOSCAN_EN.
module nibble_mux #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pba,
    input  logic [7:0] din,
    output logic [3:0] dout,
    output logic       sel,
    output logic       chg
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Parameter legality is checked at elaboration so a bad build never reaches silicon.
    if (DEBOUNCE_CYCLES < 2 || SCAN_DIV < 2) begin : g_bad_param
        $error("nibble_mux: DEBOUNCE_CYCLES and SCAN_DIV must both be >= 2");
    end

    function automatic logic [3:0] pick_nibble(input logic [7:0] bus, input logic which);
        logic [3:0] nib;
        case (which)
            1'b0:    nib = bus[3:0];
            1'b1:    nib = bus[7:4];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    logic             s1_r;
    logic             pba_s_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sel_r;
    logic             chg_r;
    logic [3:0]       dout_r;

    logic             db_s;
    logic [CNT_W-1:0] cnt_s;
    logic             accept_s;
    logic             press_s;
    logic             scan_tick_s;
    logic             toggle_s;
    logic             sel_s;
    logic             chg_s;
    logic [3:0]       dout_s;

    // Two-flop synchronizer bringing the raw button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= 1'b0;
            pba_s_r <= 1'b0;
        end else begin
            s1_r    <= pba;
            pba_s_r <= s1_r;
        end
    end

    // Debounce next-state: any cycle matching the accepted level restarts the count.
    always_comb begin
        db_s     = db_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        if (pba_s_r == db_r) begin
            cnt_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            db_s     = pba_s_r;
            cnt_s    = CNT_ZERO;
            accept_s = 1'b1;
        end else begin
            cnt_s = cnt_r + CNT_ONE;
        end
        press_s = accept_s & pba_s_r;
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_r  <= 1'b0;
            cnt_r <= CNT_ZERO;
        end else begin
            db_r  <= db_s;
            cnt_r <= cnt_s;
        end
    end

`ifdef NIBBLE_MUX_AUTOSCAN_EN
    localparam int SCN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(SCAN_DIV - 1);
    localparam logic [SCN_W-1:0] SCN_ONE  = SCN_W'(1);
    localparam logic [SCN_W-1:0] SCN_ZERO = {SCN_W{1'b0}};

    logic [SCN_W-1:0] scn_r;
    logic [SCN_W-1:0] scn_s;

    // Scan counter next-state; a press realigns the scan period to itself.
    always_comb begin
        scn_s       = scn_r;
        scan_tick_s = (scn_r == SCN_LAST);
        if (press_s || scan_tick_s) begin
            scn_s = SCN_ZERO;
        end else begin
            scn_s = scn_r + SCN_ONE;
        end
    end

    // Scan counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scn_r <= SCN_ZERO;
        end else begin
            scn_r <= scn_s;
        end
    end
`else
    assign scan_tick_s = 1'b0;
`endif

    // Select and data next-state; coincident press and scan tick merge into one toggle.
    always_comb begin
        sel_s    = sel_r;
        chg_s    = 1'b0;
        toggle_s = press_s | scan_tick_s;
        if (toggle_s) begin
            sel_s = ~sel_r;
            chg_s = 1'b1;
        end else begin
            sel_s = sel_r;
            chg_s = 1'b0;
        end
        dout_s = pick_nibble(din, sel_r);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r  <= 1'b0;
            chg_r  <= 1'b0;
            dout_r <= 4'h0;
        end else begin
            sel_r  <= sel_s;
            chg_r  <= chg_s;
            dout_r <= dout_s;
        end
    end

    assign sel  = sel_r;
    assign chg  = chg_r;
    assign dout = dout_r;

endmodule

// File: tb/tb_nibble_mux.sv
// Self-checking bench for nibble_mux: directed scenarios plus randomized traffic against a
// window-based behavioural model (a level is accepted once D synced samples all disagree with it).
module tb_nibble_mux;

    localparam int D = 4;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pba = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] dout;
    logic       sel;
    logic       chg;

    int vectors    = 0;
    int miscompares = 0;

    // model state
    bit       m_s1, m_pba_s, m_db, m_sel, m_chg;
    bit [3:0] m_dout;
    int       m_scn;
    bit       win[$];

    nibble_mux #(.DEBOUNCE_CYCLES(D), .SCAN_DIV(S)) dut (
        .clk (clk),
        .rst (rst),
        .pba (pba),
        .din (din),
        .dout(dout),
        .sel (sel),
        .chg (chg)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit acc;
        bit press;
        bit tk;
        if (rst) begin
            m_s1 = 0; m_pba_s = 0; m_db = 0; m_sel = 0; m_chg = 0; m_dout = 4'h0; m_scn = 0;
            win.delete();
        end else begin
            win.push_back(m_pba_s);
            if (win.size() > D) void'(win.pop_front());
            acc = (win.size() == D);
            foreach (win[i]) if (win[i] == m_db) acc = 0;
            press = acc && m_pba_s;
            if (acc) m_db = m_pba_s;
            tk = 0;
`ifdef NIBBLE_MUX_AUTOSCAN_EN
            tk = (m_scn == S - 1);
            m_scn = (press || tk) ? 0 : m_scn + 1;
`endif
            m_dout = m_sel ? din[7:4] : din[3:0];
            m_chg = press || tk;
            if (m_chg) m_sel = !m_sel;
            m_pba_s = m_s1;
            m_s1 = pba;
        end
    endtask

    // advance one clock edge, update the model, and return at the sampling (falling) edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 8'hA5; pba = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({dout, sel, chg} !== {4'h0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_state dout=%h sel=%b chg=%b, required 0/0/0", dout, sel, chg);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (dout !== 4'h5) begin
            miscompares++;
            $display("FAIL reset_release_dout got %h, required 5", dout);
        end
    endtask

    task automatic test_clean_press();
        din = 8'hA5; pba = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            vectors++;
            if ({dout, sel, chg} !== {m_dout, m_sel, m_chg}) begin
                miscompares++;
                $display("FAIL clean_model e=%0d got %h/%b/%b, required %h/%b/%b", e, dout, sel, chg, m_dout, m_sel, m_chg);
            end
            vectors++;
            if (sel !== (e >= 6) || chg !== (e == 6)) begin
                miscompares++;
                $display("FAIL clean_timing e=%0d sel=%b chg=%b, required sel=%b chg=%b", e, sel, chg, e >= 6, e == 6);
            end
            if (e == 7) begin
                vectors++;
                if (dout !== 4'hA) begin
                    miscompares++;
                    $display("FAIL clean_dout got %h, required a", dout);
                end
            end
        end
        pba = 1'b0;
        for (int c = 0; c < 2 * D + 4; c++) begin
            tick();
            vectors++;
            if ({dout, sel, chg} !== {m_dout, m_sel, m_chg} || chg !== 1'b0) begin
                miscompares++;
                $display("FAIL clean_release got %h/%b/%b, required %h/%b/0", dout, sel, chg, m_dout, m_sel);
            end
        end
    endtask

    task automatic test_bounce();
        bit s0;
        int pulses;
        s0 = m_sel;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                pba = (c < 3);
                tick();
                vectors++;
                if (chg !== 1'b0 || sel !== s0 || dout !== m_dout) begin
                    miscompares++;
                    $display("FAIL bounce_reject got sel=%b chg=%b dout=%h, required sel=%b chg=0 dout=%h", sel, chg, dout, s0, m_dout);
                end
            end
        end
        pba = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        pba = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            din = 8'($urandom);
            tick();
            if (chg === 1'b1) pulses++;
            vectors++;
            if ({dout, sel, chg} !== {m_dout, m_sel, m_chg}) begin
                miscompares++;
                $display("FAIL bounce_model got %h/%b/%b, required %h/%b/%b", dout, sel, chg, m_dout, m_sel, m_chg);
            end
        end
        vectors++;
        if (pulses != 1 || sel !== !s0) begin
            miscompares++;
            $display("FAIL bounce_press pulses=%0d sel=%b, required pulses=1 sel=%b", pulses, sel, !s0);
        end
        pba = 1'b0;
        for (int c = 0; c < 12; c++) tick();
    endtask

    task automatic test_release();
        rst = 1'b1; pba = 1'b0; tick(); rst = 1'b0;
        din = 8'h3C; pba = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        vectors++;
        if (sel !== 1'b1) begin
            miscompares++;
            $display("FAIL release_first_press sel=%b, required 1", sel);
        end
        pba = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if (sel !== 1'b1 || chg !== 1'b0) begin
                miscompares++;
                $display("FAIL release_ignored sel=%b chg=%b, required 1/0", sel, chg);
            end
        end
        din = 8'h9E; pba = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++;
            if ({dout, sel, chg} !== {m_dout, m_sel, m_chg}) begin
                miscompares++;
                $display("FAIL release_model got %h/%b/%b, required %h/%b/%b", dout, sel, chg, m_dout, m_sel, m_chg);
            end
        end
        vectors++;
        if (sel !== 1'b0 || dout !== 4'hE) begin
            miscompares++;
            $display("FAIL release_second_press sel=%b dout=%h, required 0/e", sel, dout);
        end
        pba = 1'b0;
        for (int c = 0; c < 12; c++) tick();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; pba = 1'b0; tick(); rst = 1'b0;
        din = 8'hA5; pba = 1'b1;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (sel !== 1'b0 || chg !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_early sel=%b chg=%b, required 0/0", sel, chg);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            vectors++;
            if (sel !== (j >= D + 2) || chg !== (j == D + 2)) begin
                miscompares++;
                $display("FAIL midreset_timing j=%0d sel=%b chg=%b, required sel=%b chg=%b", j, sel, chg, j >= D + 2, j == D + 2);
            end
            if (j == D + 3) begin
                vectors++;
                if (dout !== 4'hA) begin
                    miscompares++;
                    $display("FAIL midreset_dout got %h, required a", dout);
                end
            end
        end
        pba = 1'b0;
        for (int c = 0; c < 12; c++) tick();
    endtask

`ifdef NIBBLE_MUX_AUTOSCAN_EN
    task automatic test_autoscan();
        bit exp_sel;
        rst = 1'b1; pba = 1'b0; din = 8'h5A; tick(); rst = 1'b0;
        for (int j = 1; j <= 26; j++) begin
            if (j == 11) pba = 1'b1;
            tick();
            exp_sel = ((j >= 8 && j < 16) || j >= 24);
            vectors++;
            if (sel !== exp_sel || chg !== (j == 8 || j == 16 || j == 24)) begin
                miscompares++;
                $display("FAIL autoscan j=%0d sel=%b chg=%b, required sel=%b chg=%b", j, sel, chg, exp_sel, j == 8 || j == 16 || j == 24);
            end
            vectors++;
            if ({dout, sel, chg} !== {m_dout, m_sel, m_chg}) begin
                miscompares++;
                $display("FAIL autoscan_model got %h/%b/%b, required %h/%b/%b", dout, sel, chg, m_dout, m_sel, m_chg);
            end
        end
        pba = 1'b0;
        for (int c = 0; c < 12; c++) tick();
    endtask
`endif

    task automatic test_random();
        int hold;
        for (int n = 0; n < 60; n++) begin
            pba  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
            rst  = ($urandom_range(0, 24) == 0);
            for (int c = 0; c < hold; c++) begin
                din = 8'($urandom);
                tick();
                rst = 1'b0;
                vectors++;
                if ({dout, sel, chg} !== {m_dout, m_sel, m_chg}) begin
                    miscompares++;
                    $display("FAIL random_model n=%0d got %h/%b/%b, required %h/%b/%b", n, dout, sel, chg, m_dout, m_sel, m_chg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef NIBBLE_MUX_AUTOSCAN_EN
        test_autoscan();
`else
        test_clean_press();
        test_bounce();
        test_release();
        test_reset_mid();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
